// File: rtl/isr_pkg.sv
// Shared definitions for the ISR prefetch queue: instruction width, reset value
// and the wrap-around pointer increment used for non-power-of-2 depths.
package isr_pkg;

  localparam int ISR_W = 16;
  localparam logic [ISR_W-1:0] ISR_RESET_VAL = 16'h0000;

  // Wrap by explicit compare so any depth (not only 2^n) works.
  function automatic int unsigned next_ptr(input int unsigned ptr, input int unsigned depth);
    return (ptr == depth - 32'd1) ? 32'd0 : ptr + 32'd1;
  endfunction

endpackage

// File: rtl/isr_fifo_mem.sv
// DEPTH x WIDTH register array: one synchronous write port, one asynchronous read port.
// Storage is intentionally not reset.
module isr_fifo_mem
  import isr_pkg::*;
#(
  parameter int WIDTH = ISR_W,
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  always_ff @(posedge CLK) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/isr_prefetch_queue.sv
// Prefetch FIFO in front of the instruction register: queues fetched words,
// loads ISR from the head on MIS, bypasses straight to ISR when empty.
module isr_prefetch_queue
  import isr_pkg::*;
#(
  parameter int WIDTH = ISR_W,
  parameter int DEPTH = 4,
  localparam int CNT_W = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             CLR,
  input  logic [WIDTH-1:0] m_bus,
  input  logic             fetch_valid,
  output logic             fetch_ready,
  input  logic             MIS,
  input  logic             flush,
  output logic [WIDTH-1:0] ISR,
  output logic             isr_valid,
  output logic [CNT_W-1:0] q_count,
  output logic             q_empty,
  output logic             q_full,
  output logic             underrun,
  output logic             overflow
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic [PTR_W-1:0] rd_ptr, wr_ptr;
  logic [WIDTH-1:0] head;
  logic             pop_q, bypass, push, drop, starve;

  assign q_empty     = (q_count == '0);
  assign q_full      = (q_count == FULL_CNT);
  assign fetch_ready = !q_full;

  // A full queue still accepts a word when a pop frees the head slot on the same edge.
  assign pop_q  = !flush && MIS && !q_empty;
  assign bypass = !flush && MIS && q_empty && fetch_valid;
  assign push   = !flush && fetch_valid && !bypass && (!q_full || MIS);
  assign drop   = !flush && fetch_valid && q_full && !MIS;
  assign starve = !flush && MIS && q_empty && !fetch_valid;

  isr_fifo_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH)
  ) u_mem (
    .CLK   (CLK),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (m_bus),
    .raddr (rd_ptr),
    .rdata (head)
  );

  always_ff @(posedge CLK or negedge CLR) begin
    if (!CLR) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      q_count   <= '0;
      ISR       <= ISR_RESET_VAL;
      isr_valid <= 1'b0;
      underrun  <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      underrun <= starve;
      overflow <= drop;
      if (flush) begin
        rd_ptr    <= '0;
        wr_ptr    <= '0;
        q_count   <= '0;
        isr_valid <= 1'b0;
      end else begin
        if (push) wr_ptr <= PTR_W'(next_ptr(32'(wr_ptr), DEPTH));
        if (pop_q) begin
          rd_ptr    <= PTR_W'(next_ptr(32'(rd_ptr), DEPTH));
          ISR       <= head;
          isr_valid <= 1'b1;
        end else if (bypass) begin
          ISR       <= m_bus;
          isr_valid <= 1'b1;
        end
        if (push && !pop_q)      q_count <= q_count + 1'b1;
        else if (pop_q && !push) q_count <= q_count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_isr_prefetch_queue.sv
// Bench for isr_prefetch_queue: vector table on a DEPTH=4 instance, reset
// corner cases, and a scoreboard-checked wrap run on a DEPTH=3 instance.
module tb_isr_prefetch_queue;

  logic        CLK = 1'b0;
  logic        CLR = 1'b0;

  logic [15:0] m_bus = '0;
  logic        fetch_valid = 1'b0, MIS = 1'b0, flush = 1'b0;
  logic        fetch_ready, isr_valid, q_empty, q_full, underrun, overflow;
  logic [15:0] ISR;
  logic [2:0]  q_count;

  logic [15:0] m_bus3 = '0;
  logic        fetch_valid3 = 1'b0, MIS3 = 1'b0;
  logic        fetch_ready3, isr_valid3, q_empty3, q_full3, underrun3, overflow3;
  logic [15:0] ISR3;
  logic [1:0]  q_count3;

  int tests = 0;
  int fails = 0;

  always #5 CLK = ~CLK;

  isr_prefetch_queue #(.WIDTH(16), .DEPTH(4)) dut (
    .CLK(CLK), .CLR(CLR), .m_bus(m_bus), .fetch_valid(fetch_valid),
    .fetch_ready(fetch_ready), .MIS(MIS), .flush(flush), .ISR(ISR),
    .isr_valid(isr_valid), .q_count(q_count), .q_empty(q_empty),
    .q_full(q_full), .underrun(underrun), .overflow(overflow)
  );

  isr_prefetch_queue #(.WIDTH(16), .DEPTH(3)) dut3 (
    .CLK(CLK), .CLR(CLR), .m_bus(m_bus3), .fetch_valid(fetch_valid3),
    .fetch_ready(fetch_ready3), .MIS(MIS3), .flush(1'b0), .ISR(ISR3),
    .isr_valid(isr_valid3), .q_count(q_count3), .q_empty(q_empty3),
    .q_full(q_full3), .underrun(underrun3), .overflow(overflow3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic fv, input logic mis, input logic fl, input logic [15:0] d);
    @(negedge CLK);
    fetch_valid = fv; MIS = mis; flush = fl; m_bus = d;
    @(posedge CLK);
    #1;
    fetch_valid = 1'b0; MIS = 1'b0; flush = 1'b0;
  endtask

  task automatic chk_state(input string tag, input logic [15:0] isr_e, input logic val_e, input int cnt_e);
    chk({tag, "_isr"},   32'(ISR), 32'(isr_e));
    chk({tag, "_valid"}, 32'(isr_valid), 32'(val_e));
    chk({tag, "_cnt"},   32'(q_count), 32'(cnt_e));
    chk({tag, "_empty"}, 32'(q_empty), 32'(cnt_e == 0));
    chk({tag, "_full"},  32'(q_full), 32'(cnt_e == 4));
    chk({tag, "_ready"}, 32'(fetch_ready), 32'(cnt_e != 4));
  endtask

  typedef struct {
    logic        fv, mis, fl;
    logic [15:0] data;
    logic [15:0] isr;
    logic        val;
    int          cnt;
    logic        udr, ovf;
  } vec_t;

  vec_t vecs[20];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    // fill, overflow drop, full+simultaneous, drain, underrun, bypass, flush
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 16'h1111, 16'h0000, 1'b0, 1, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 16'h2222, 16'h0000, 1'b0, 2, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 16'h3333, 16'h0000, 1'b0, 3, 1'b0, 1'b0};
    vecs[3]  = '{1'b1, 1'b0, 1'b0, 16'h4444, 16'h0000, 1'b0, 4, 1'b0, 1'b0};
    vecs[4]  = '{1'b1, 1'b0, 1'b0, 16'h6666, 16'h0000, 1'b0, 4, 1'b0, 1'b1};
    vecs[5]  = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 4, 1'b0, 1'b0};
    vecs[6]  = '{1'b1, 1'b1, 1'b0, 16'h5555, 16'h1111, 1'b1, 4, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h2222, 1'b1, 3, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h3333, 1'b1, 2, 1'b0, 1'b0};
    vecs[9]  = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h4444, 1'b1, 1, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555, 1'b1, 0, 1'b0, 1'b0};
    vecs[11] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h5555, 1'b1, 0, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'h5555, 1'b1, 0, 1'b0, 1'b0};
    vecs[13] = '{1'b1, 1'b1, 1'b0, 16'hA5A5, 16'hA5A5, 1'b1, 0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 1'b0, 1'b0, 16'h0000, 16'hA5A5, 1'b1, 0, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 1'b0, 1'b0, 16'h0123, 16'hA5A5, 1'b1, 1, 1'b0, 1'b0};
    vecs[16] = '{1'b1, 1'b0, 1'b0, 16'h0456, 16'hA5A5, 1'b1, 2, 1'b0, 1'b0};
    vecs[17] = '{1'b1, 1'b1, 1'b1, 16'h0789, 16'hA5A5, 1'b0, 0, 1'b0, 1'b0};
    vecs[18] = '{1'b1, 1'b0, 1'b0, 16'h0AAA, 16'hA5A5, 1'b0, 1, 1'b0, 1'b0};
    vecs[19] = '{1'b0, 1'b1, 1'b0, 16'h0000, 16'h0AAA, 1'b1, 0, 1'b0, 1'b0};

    #12;
    chk_state("por", 16'h0000, 1'b0, 0);
    chk("por_udr", 32'(underrun), 32'd0);
    chk("por_ovf", 32'(overflow), 32'd0);
    @(negedge CLK);
    CLR = 1'b1;

    for (int i = 0; i < 20; i++) begin
      drive(vecs[i].fv, vecs[i].mis, vecs[i].fl, vecs[i].data);
      chk_state($sformatf("vec%0d", i), vecs[i].isr, vecs[i].val, vecs[i].cnt);
      chk($sformatf("vec%0d_udr", i), 32'(underrun), 32'(vecs[i].udr));
      chk($sformatf("vec%0d_ovf", i), 32'(overflow), 32'(vecs[i].ovf));
    end

    // asynchronous reset mid-run with three words queued
    drive(1'b1, 1'b0, 1'b0, 16'hC001);
    drive(1'b1, 1'b0, 1'b0, 16'hC002);
    drive(1'b1, 1'b0, 1'b0, 16'hC003);
    chk("pre_rst_cnt", 32'(q_count), 32'd3);
    @(negedge CLK);
    #2 CLR = 1'b0;
    #1;
    chk_state("async_rst", 16'h0000, 1'b0, 0);
    @(negedge CLK);
    CLR = 1'b1;
    drive(1'b1, 1'b0, 1'b0, 16'hBEEF);
    chk_state("post_rst_push", 16'h0000, 1'b0, 1);
    drive(1'b0, 1'b1, 1'b0, 16'h0000);
    chk_state("post_rst_pop", 16'hBEEF, 1'b1, 0);

    // DEPTH=3 wrap run against a scoreboard
    begin
      logic [15:0] sb[$];
      logic        fv, mis, expect_out;
      logic [15:0] d;
      int          cnt;
      for (int c = 0; c < 80; c++) begin
        fv  = ($urandom_range(0, 99) < 60);
        mis = ($urandom_range(0, 99) < 45);
        d   = 16'($urandom);
        cnt = sb.size();
        expect_out = mis && (cnt > 0 || fv);
        if (fv && ((mis && cnt == 0) || cnt < 3 || mis)) sb.push_back(d);
        @(negedge CLK);
        fetch_valid3 = fv; MIS3 = mis; m_bus3 = d;
        @(posedge CLK);
        #1;
        fetch_valid3 = 1'b0; MIS3 = 1'b0;
        if (expect_out) chk($sformatf("wrap%0d_isr", c), 32'(ISR3), 32'(sb.pop_front()));
        chk($sformatf("wrap%0d_cnt", c), 32'(q_count3), 32'(sb.size()));
        chk($sformatf("wrap%0d_le3", c), 32'(q_count3 <= 2'd3 && !(q_full3 && q_count3 != 2'd3)), 32'd1);
      end
      // drain whatever is left, strictly in order
      while (sb.size() > 0) begin
        @(negedge CLK);
        MIS3 = 1'b1;
        @(posedge CLK);
        #1;
        MIS3 = 1'b0;
        chk("drain_isr", 32'(ISR3), 32'(sb.pop_front()));
      end
      chk("drain_empty", 32'(q_empty3), 32'd1);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
